pwm_multi_drv: RTL
==================

# pwm_multi_drv

Parametrised multi-channel PWM generator on the host bus. It is the next generation of the three-LED PWM driver and adds several features: a configurable channel count and counter width, a shared prescaler and period, edge- or center-aligned mode, per-channel polarity, and shadowed period/duty registers that reload glitch-free at period boundaries. It decodes its own register window from the host bus chip-select and is readable through `host_rd_data`.

## Interface
Parameters:
- `NUM_CH`, 3, number of PWM channels (1..16).
- `CNT_W`, 16, counter/period/duty width in bits (2..16). Upper bits of 16-bit writes are ignored; reads are zero-extended.

Ports:
- `host_clk`  in  1  sole clock.
- `host_rst_l`  in  1  reset; asynchronous assert, active-low.
- `host_addr`  in  16  register word address; only `[7:0]` is decoded.
- `host_wr_data`  in  16  write data.
- `host_rd_data`  out  16  registered read data.
- `host_cs`  in  1  block select.
- `host_rd_en`  in  1  read strobe, qualified by `host_cs`.
- `host_wr_en`  in  1  write strobe, qualified by `host_cs`.
- `pwm`  out  `NUM_CH`  registered PWM outputs; bit i is channel i.
- `period_strobe`  out  1  one-clock pulse at each period boundary.

## Operation
Register map:
- 0x00 CTRL (RW)
  - `[0]` EN.
  - `[1]` CENTER: 0 selects edge-aligned, 1 selects center-aligned.
- 0x01 PRESCALE (RW, `CNT_W` bits).
- 0x02 PERIOD (RW, shadowed).
- 0x03 POL (RW, `NUM_CH` bits): 1 inverts the channel.
- 0x04 CNT (RO): current counter value.
- 0x10+i DUTY[i] (RW, shadowed), for i < `NUM_CH`.
- All other addresses: writes are ignored and reads return 0.
- All registers reset to 0. Reads of PERIOD and DUTY return the shadow value.

Write and read behaviour:
- A write takes effect on the clock edge where `host_cs & host_wr_en` is high.
- On a read (`host_cs & host_rd_en`), `host_rd_data` is loaded on that edge.

Tick generation:
- The prescaler `pre` counts 0..PRESCALE.
- `tick` is asserted when `pre == PRESCALE`, which gives one tick per PRESCALE+1 clocks.
- The counter advances only on a tick.

Edge mode:
- `cnt` counts 0,1,…,PERIOD, then wraps to 0. The period is PERIOD+1 ticks.
- The boundary is the tick on which `cnt` wraps to 0.

Center mode:
- `cnt` counts up 0..PERIOD, then down PERIOD-1..1, then repeats from 0. The period is 2·PERIOD ticks.
- The boundary is the tick that sets `cnt` to 0.
- With PERIOD = 0, `cnt` stays at 0 and a boundary occurs on every tick.

Channel output:
- `raw_i = (cnt < duty_act[i])`.
- DUTY = 0 gives a constant low `raw`; DUTY > PERIOD gives a constant high `raw`.
- In center mode the high width is 2·DUTY−1 ticks for 0 < DUTY ≤ PERIOD, centred on `cnt` = 0.
- `pwm[i] = EN ? raw_i ^ POL[i] : POL[i]`.

Shadow loading:
- `period_act` and `duty_act` load from the shadows at each boundary, and on every clock while EN = 0.
- If a shadow write and a boundary happen in the same cycle, the active copy loads the pre-write shadow value. The new value applies from the following boundary.
- PRESCALE, POL and CENTER act immediately.

Disabling:
- When EN = 0, `pre` and `cnt` are held at 0 with direction up, and `period_strobe` is 0.
- Clearing EN mid-period takes effect on the next edge; there is no completion of the current period.

Enabling:
- Setting EN starts counting from `cnt` = 0 using the current shadow values.

Mode change:
- Changing CENTER while enabled resets `cnt` to 0 with direction up on the next edge. This does not count as a boundary.

## Timing
- All outputs are registered. Reset values: `pwm` = 0 (POL resets to 0), `period_strobe` = 0, `host_rd_data` = 0.
- `pwm` reflects the `cnt`, `duty_act` and POL values of the previous clock, a latency of 1 clock.
- `period_strobe` is high for exactly 1 clock, in the clock following the boundary edge, aligned with the first output clock of the new period.
- A write to EN or POL affects `pwm` 2 edges after the write edge.
- `host_rd_data` is valid the clock after the read strobe and holds until the next read.
- Asserting reset mid-operation clears all state immediately and forces `pwm` to 0, regardless of the earlier POL value.

## Test plan
- **Reset:** assert `host_rst_l` = 0 mid-run → `pwm` = 0, `period_strobe` = 0, `host_rd_data` = 0. After release, reading 0x00..0x04 and 0x10..0x12 all return 0.
- **Edge mode:** PRESCALE = 0, PERIOD = 9, DUTY = {3,0,10}, EN = 1 → `pwm[0]` high 3 of every 10 clocks, `pwm[1]` constantly 0, `pwm[2]` constantly 1, `period_strobe` every 10 clocks. Reading 0x04 returns values in 0..9.
- **Shadow reload:** with the edge-mode setup running, write DUTY0 = 7 at `cnt` = 5 → the current period keeps a 3-clock high. From the next `period_strobe` the high time is 7 clocks. A write on the boundary cycle itself is delayed by one further period.
- **Center mode:** CTRL = 0x3, PERIOD = 4, DUTY0 = 2 → `cnt` sequence 0,1,2,3,4,3,2,1 repeats, `pwm[0]` high 3 of every 8 clocks, `period_strobe` every 8 clocks.
- **Prescale and polarity:** PRESCALE = 3, PERIOD = 9, DUTY0 = 3, POL = 0x1 → `cnt` advances every 4 clocks, the period is 40 clocks, and `pwm[0]` is low for 12 clocks and high for 28.
- **Disable mid-period:** clear EN at `cnt` = 6 → `pwm` = POL 2 edges after the write, CNT reads 0, no `period_strobe`. Re-enabling restarts from `cnt` = 0 with the latest DUTY/PERIOD values.

Source files
------------

// File: rtl/pwm_multi_drv.sv
// Multi-channel PWM generator with a shared prescaler/period, edge or center alignment and shadowed duty/period.
// pwm and period_strobe are registered (1 clock after cnt); host reads return data 1 clock after the strobe; no backpressure.
module pwm_multi_drv #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic              host_clk,
  input  logic              host_rst_l,
  input  logic [15:0]       host_addr,
  input  logic [15:0]       host_wr_data,
  output logic [15:0]       host_rd_data,
  input  logic              host_cs,
  input  logic              host_rd_en,
  input  logic              host_wr_en,
  output logic [NUM_CH-1:0] pwm,
  output logic              period_strobe
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [7:0]       A_CTRL     = 8'h00;
  localparam logic [7:0]       A_PRESCALE = 8'h01;
  localparam logic [7:0]       A_PERIOD   = 8'h02;
  localparam logic [7:0]       A_POL      = 8'h03;
  localparam logic [7:0]       A_CNT      = 8'h04;

  logic [1:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  prescale_q, prescale_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [NUM_CH-1:0] pol_q, pol_d;
  logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [CNT_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_dn_q, dir_dn_d;
  logic              bnd_q, bnd_d;
  logic              strobe_q, strobe_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [15:0]       rd_data_q, rd_data_d;

  logic [7:0]       addr;
  logic [CNT_W-1:0] wdat;
  logic             wr, rd, en, center, tick, mode_chg, bnd, load;
  logic [15:0]      rd_val;
  logic             unused_bits;

  assign addr        = host_addr[7:0];
  assign wdat        = host_wr_data[CNT_W-1:0];
  assign wr          = host_cs & host_wr_en;
  assign rd          = host_cs & host_rd_en;
  assign en          = ctrl_q[0];
  assign center      = ctrl_q[1];
  assign unused_bits = ^{host_addr[15:8], host_wr_data};

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    period_sh_d = period_sh_q;
    pol_d       = pol_q;
    duty_sh_d   = duty_sh_q;
    if (wr) begin
      case (addr)
        A_CTRL:     ctrl_d      = host_wr_data[1:0];
        A_PRESCALE: prescale_d  = wdat;
        A_PERIOD:   period_sh_d = wdat;
        A_POL:      pol_d       = host_wr_data[NUM_CH-1:0];
        default:    ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (addr == 8'(16 + i)) duty_sh_d[i] = wdat;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      A_CTRL:     rd_val = {14'd0, ctrl_q};
      A_PRESCALE: rd_val = 16'(prescale_q);
      A_PERIOD:   rd_val = 16'(period_sh_q);
      A_POL:      rd_val = 16'(pol_q);
      A_CNT:      rd_val = 16'(cnt_q);
      default:    ;
    endcase
    for (int i = 0; i < NUM_CH; i++)
      if (addr == 8'(16 + i)) rd_val = 16'(duty_sh_q[i]);
    rd_data_d = rd ? rd_val : rd_data_q;
  end

  // A CENTER flip while running restarts the count on the write edge without a boundary.
  assign mode_chg = wr && (addr == A_CTRL) && (host_wr_data[1] != center);
  assign tick     = en && (pre_q >= prescale_q);

  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;
    bnd      = 1'b0;
    if (!en || mode_chg) begin
      pre_d    = '0;
      cnt_d    = '0;
      dir_dn_d = 1'b0;
    end else begin
      pre_d = tick ? '0 : pre_q + ONE;
      if (tick) begin
        if (!center) begin
          if (cnt_q >= period_act_q) begin
            cnt_d = '0;
            bnd   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (period_act_q == '0) begin
          cnt_d    = '0;
          dir_dn_d = 1'b0;
          bnd      = 1'b1;
        end else if (!dir_dn_q) begin
          if (cnt_q >= period_act_q) begin
            if (period_act_q == ONE) begin
              cnt_d = '0;
              bnd   = 1'b1;
            end else begin
              cnt_d    = period_act_q - ONE;
              dir_dn_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (cnt_q <= ONE) begin
          cnt_d    = '0;
          dir_dn_d = 1'b0;
          bnd      = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // Active copies sample the pre-write shadows, so a same-edge write waits one more period.
  assign load = !en || bnd;

  always_comb begin
    period_act_d = load ? period_sh_q : period_act_q;
    duty_act_d   = load ? duty_sh_q : duty_act_q;
    bnd_d        = bnd;
    strobe_d     = en && bnd_q;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = en ? ((cnt_q < duty_act_q[i]) ^ pol_q[i]) : pol_q[i];
  end

  always_ff @(posedge host_clk or negedge host_rst_l) begin
    if (!host_rst_l) begin
      ctrl_q       <= '0;
      prescale_q   <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      pol_q        <= '0;
      duty_sh_q    <= '{default: '0};
      duty_act_q   <= '{default: '0};
      pre_q        <= '0;
      cnt_q        <= '0;
      dir_dn_q     <= 1'b0;
      bnd_q        <= 1'b0;
      strobe_q     <= 1'b0;
      pwm_q        <= '0;
      rd_data_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      prescale_q   <= prescale_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      pol_q        <= pol_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      dir_dn_q     <= dir_dn_d;
      bnd_q        <= bnd_d;
      strobe_q     <= strobe_d;
      pwm_q        <= pwm_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign pwm           = pwm_q;
  assign period_strobe = strobe_q;
  assign host_rd_data  = rd_data_q;

endmodule
